axis_sum_dump: RTL and testbench

Sum-and-dump decimator for the AXI4-Stream sample path directly downstream of the `dsp48` rounding multiplier. It accepts one signed product per cycle from the multiplier's `P` output, wrapped in AXI4-Stream handshakes by the surrounding logic. It accumulates a run-time-programmable number of consecutive samples, with saturation, and emits one sum per block on an output stream. A one-entry output register decouples the two sides: back-pressure reaches the input only on the sample that closes a block.

---
 rtl/axis_sum_dump.sv | 101 ++++++++++
 tb/tb_axis_sum_dump.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axis_sum_dump.sv
// Sum-and-dump decimator: accumulates N signed samples with saturation and
// emits one block sum through a single-entry AXI4-Stream output register.
module axis_sum_dump #(
    parameter int unsigned S_AXIS_TDATA_WIDTH = 24,
    parameter int unsigned M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNTR_WIDTH         = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [CNTR_WIDTH-1:0]         cfg_data,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int unsigned SW = S_AXIS_TDATA_WIDTH;
    localparam int unsigned MW = M_AXIS_TDATA_WIDTH;
    localparam int unsigned CW = CNTR_WIDTH;

    logic signed [MW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        lim_q, lim_d;
    logic [MW-1:0]        tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;

    logic [CW-1:0]        cfg_lim;
    logic [CW-1:0]        lim;
    logic                 last;
    logic                 accept;
    logic signed [SW-1:0] s_sample;
    logic signed [MW-1:0] x_ext;
    logic signed [MW:0]   sum_w;
    logic signed [MW-1:0] sum_sat;

    // Block length, sign extension and saturating sum
    always_comb begin
        cfg_lim  = (cfg_data == '0) ? '0 : cfg_data - CW'(1);
        lim      = (cnt_q == '0) ? cfg_lim : lim_q;
        last     = (cnt_q == lim);
        s_sample = s_axis_tdata;
        x_ext    = MW'(s_sample);
        sum_w    = (MW+1)'(acc_q) + (MW+1)'(x_ext);
        if (sum_w[MW] != sum_w[MW-1]) begin
            sum_sat = sum_w[MW] ? {1'b1, {(MW-1){1'b0}}} : {1'b0, {(MW-1){1'b1}}};
        end else begin
            sum_sat = sum_w[MW-1:0];
        end
    end

    // Back-pressure reaches the input only on the block-closing sample
    assign s_axis_tready = ~RST & (~last | ~tvalid_q | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        lim_d    = lim_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        if (accept) begin
            if (cnt_q == '0) begin
                lim_d = lim;
            end
            if (last) begin
                tdata_d  = sum_sat;
                tvalid_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = sum_sat;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            lim_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            lim_q    <= lim_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_sum_dump.sv
// Directed bench for axis_sum_dump; expected sums are queued by the stimulus
// and consumed by an output monitor on every completed output handshake.
module tb_axis_sum_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_data = 16'd4;
    logic [23:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    axis_sum_dump dut (
        .CLK           (clk),
        .RST           (rst),
        .cfg_data      (cfg_data),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Present one sample and hold it until accepted; reports stall cycles
    task automatic send(input logic [23:0] d, output int stalls);
        stalls   = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && stalls < 200) begin
            @(negedge clk);
            stalls++;
        end
        if (!s_tready) check("send_timeout", 32'(stalls), 32'd0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    // Output monitor: data stability under stall, and scoreboard compare
    logic        held_valid = 1'b0;
    logic [31:0] held_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_data", m_tdata, held_data);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", m_tdata, 32'hxxxxxxxx);
                end else begin
                    check("output_sum", m_tdata, exp_q.pop_front());
                end
            end
            held_valid = m_tvalid && !m_tready;
            held_data  = m_tdata;
        end
    end

    initial begin
        int st;
        int total;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_tready", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic block sum, one-cycle valid pulse
        cfg_data = 16'd4;
        exp_q.push_back(32'h0000000A);
        send(24'd1, st); send(24'd2, st); send(24'd3, st); send(24'd4, st);
        check("basic_valid_rise", 32'(m_tvalid), 32'd1);
        @(posedge clk); #1;
        check("basic_valid_fall", 32'(m_tvalid), 32'd0);

        // N = 0 and N = 1 passthrough with sign extension, no stalls
        for (int n = 0; n < 2; n++) begin
            cfg_data = 16'(n);
            exp_q.push_back(32'hFF800000);
            exp_q.push_back(32'h007FFFFF);
            total = 0;
            send(24'h800000, st); total += st;
            send(24'h7FFFFF, st); total += st;
            check("passthru_stalls", 32'(total), 32'd0);
        end

        // Saturation positive and negative
        cfg_data = 16'd600;
        exp_q.push_back(32'h7FFFFFFF);
        for (int i = 0; i < 600; i++) send(24'h7FFFFF, st);
        exp_q.push_back(32'h80000000);
        for (int i = 0; i < 600; i++) send(24'h800000, st);
        repeat (2) @(posedge clk);
        #1;

        // Back-pressure: only the second block's closing sample stalls
        cfg_data = 16'd2;
        m_tready = 1'b0;
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd6);
        send(24'd1, st); send(24'd1, st);
        send(24'd2, st);
        check("bp_first2_stalls", 32'(st), 32'd0);
        fork
            begin
                send(24'd2, st);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_tready_low", 32'(s_tready), 32'd0);
                    check("bp_held_sum", m_tdata, 32'd2);
                end
                @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        send(24'd3, st);
        check("bp_third_stalls", 32'(st), 32'd0);
        send(24'd3, st);

        // Mid-block length change applies to next block
        cfg_data = 16'd3;
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd5);
        send(24'd1, st);
        cfg_data = 16'd5;
        send(24'd1, st); send(24'd1, st);
        for (int i = 0; i < 5; i++) send(24'd1, st);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-block with a pending output
        cfg_data = 16'd4;
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) send(24'd1, st);
        send(24'd1, st); send(24'd1, st);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tready", 32'(s_tready), 32'd0);
        @(posedge clk); #1;
        check("midrst_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst_tready2", 32'(s_tready), 32'd0);
        rst = 1'b0;
        m_tready = 1'b1;
        exp_q.push_back(32'h00000014);
        for (int i = 0; i < 4; i++) send(24'd5, st);

        // Drain scoreboard with a bound
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
